// File: rtl/tracer_pkg.sv
// Shared tracer types: the RVFI retirement record and default retire-buffer depth.
package tracer_pkg;

  localparam int unsigned RvfiBufDepth = 8;
  localparam int unsigned RvfiOrderW   = 64;

  typedef struct packed {
    logic [RvfiOrderW-1:0] order;
    logic [31:0]           insn;
    logic [31:0]           pc;
    logic [4:0]            rd_addr;
    logic [31:0]           rd_wdata;
  } rvfi_t;

endpackage

// File: rtl/rvfi_retire_buf.sv
// Dual-issue RVFI retirement buffer: stamps a running order and drains one record per cycle.
// Optional saturating drop counter built only when RVFI_DROP_CNT_EN is defined.
module rvfi_retire_buf
  import tracer_pkg::*;
#(
  parameter int unsigned DEPTH    = RvfiBufDepth,
  parameter int unsigned DropCntW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          in_valid_i,
  input  rvfi_t               in_data0_i,
  input  rvfi_t               in_data1_i,
  output logic                in_rdy_o,
  output logic                out_valid_o,
  output rvfi_t               out_data_o,
  input  logic                out_rdy_i,
  output logic [DropCntW-1:0] drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] RdyMax = CntW'(DEPTH - 2);

  rvfi_t                 mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, wr_idx1;
  logic [CntW-1:0]       count_q;
  logic [RvfiOrderW-1:0] order_q;
  logic [1:0]            acc, push_n;
  logic                  pop;
  rvfi_t                 wr_rec0, wr_rec1;

  // Ready is judged on the registered count only, so a same-cycle pop never frees room.
  assign in_rdy_o    = rst_i | (count_q <= RdyMax);
  assign out_valid_o = ~rst_i & (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign acc    = in_valid_i & {2{in_rdy_o}};
  assign push_n = {1'b0, acc[0]} + {1'b0, acc[1]};
  assign pop    = out_valid_o & out_rdy_i;

  always_comb begin
    wr_rec0       = in_data0_i;
    wr_rec0.order = order_q;
    wr_rec1       = in_data1_i;
    wr_rec1.order = order_q + RvfiOrderW'(acc[0]);
    wr_idx1       = wr_ptr_q + PtrW'(acc[0]);
  end

  always_ff @(posedge clk_i) begin
    if (acc[0]) mem_q[wr_ptr_q] <= wr_rec0;
    if (acc[1]) mem_q[wr_idx1]  <= wr_rec1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      order_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(push_n);
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      count_q  <= count_q + CntW'(push_n) - CntW'(pop);
      if (|acc) order_q <= order_q + RvfiOrderW'(push_n);
    end
  end

`ifdef RVFI_DROP_CNT_EN
  logic [1:0]          drop_n;
  logic [DropCntW:0]   drop_sum;
  logic [DropCntW-1:0] drop_q;

  assign drop_n   = {1'b0, in_valid_i[0] & ~in_rdy_o} + {1'b0, in_valid_i[1] & ~in_rdy_o};
  assign drop_sum = {1'b0, drop_q} + (DropCntW + 1)'(drop_n);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= '0;
    end else if (drop_sum[DropCntW]) begin
      drop_q <= '1;
    end else begin
      drop_q <= drop_sum[DropCntW-1:0];
    end
  end

  assign drop_cnt_o = rst_i ? '0 : drop_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rvfi_retire_buf.sv
// Self-checking bench for rvfi_retire_buf: queue-based reference model plus directed literal checks.
module tb_rvfi_retire_buf;
  import tracer_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
`ifdef RVFI_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    in_valid_i = 2'b00;
  rvfi_t         in_data0_i = '0;
  rvfi_t         in_data1_i = '0;
  logic          in_rdy_o;
  logic          out_valid_o;
  rvfi_t         out_data_o;
  logic          out_rdy_i = 1'b0;
  logic [DW-1:0] drop_cnt_o;

  rvfi_retire_buf #(.DEPTH(DEPTH), .DropCntW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i),
    .in_data0_i(in_data0_i), .in_data1_i(in_data1_i), .in_rdy_o(in_rdy_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_rdy_i(out_rdy_i),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of records, a running order and a saturating drop tally.
  rvfi_t       mq[$];
  logic [63:0] m_ord = '0;
  int          m_drop = 0;
  bit          m_rdy;
  rvfi_t       m_rec;

  always @(posedge clk_i) begin
    if (rst_i) begin
      mq.delete();
      m_ord  = '0;
      m_drop = 0;
    end else begin
      m_rdy = (mq.size() <= DEPTH - 2);
      if (mq.size() > 0 && out_rdy_i) void'(mq.pop_front());
      for (int s = 0; s < 2; s++) begin
        if (in_valid_i[s]) begin
          if (m_rdy) begin
            m_rec       = (s == 0) ? in_data0_i : in_data1_i;
            m_rec.order = m_ord;
            m_ord       = m_ord + 64'd1;
            mq.push_back(m_rec);
          end else if (DROP_EN && m_drop < (1 << DW) - 1) begin
            m_drop++;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_in_rdy", in_rdy_o, 1);
      chk("rst_drop_cnt", drop_cnt_o, 0);
    end else begin
      chk("out_valid", out_valid_o, mq.size() != 0);
      chk("in_rdy", in_rdy_o, mq.size() <= DEPTH - 2);
      chk("drop_cnt", drop_cnt_o, m_drop);
      if (mq.size() != 0) chk("out_data", out_data_o, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(logic [1:0] v, logic [31:0] pc0, logic [31:0] pc1);
    in_valid_i          = v;
    in_data0_i          = '0;
    in_data0_i.order    = 64'hDEAD_BEEF;
    in_data0_i.pc       = pc0;
    in_data0_i.insn     = $urandom;
    in_data0_i.rd_addr  = 5'($urandom);
    in_data0_i.rd_wdata = $urandom;
    in_data1_i          = '0;
    in_data1_i.order    = 64'hCAFE_F00D;
    in_data1_i.pc       = pc1;
    in_data1_i.insn     = $urandom;
    in_data1_i.rd_addr  = 5'($urandom);
    in_data1_i.rd_wdata = $urandom;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    chk("lit_rst_valid", out_valid_o, 0);
    chk("lit_rst_rdy", in_rdy_o, 1);
    rst_i = 1'b0;
    tick();
    chk("lit_post_rst_valid", out_valid_o, 0);
    chk("lit_post_rst_rdy", in_rdy_o, 1);
    chk("lit_post_rst_drop", drop_cnt_o, 0);

    // dual push, tracer ready
    out_rdy_i = 1'b1;
    set_in(2'b11, 32'h1000, 32'h1004);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_dual_valid0", out_valid_o, 1);
    chk("lit_dual_order0", out_data_o.order, 0);
    chk("lit_dual_pc0", out_data_o.pc, 32'h1000);
    tick();
    chk("lit_dual_valid1", out_valid_o, 1);
    chk("lit_dual_order1", out_data_o.order, 1);
    chk("lit_dual_pc1", out_data_o.pc, 32'h1004);
    tick();
    chk("lit_dual_empty", out_valid_o, 0);

    // slot-1 only push
    do_reset();
    tick();
    set_in(2'b10, 32'h555, 32'h100);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_slot1_valid", out_valid_o, 1);
    chk("lit_slot1_pc", out_data_o.pc, 32'h100);
    chk("lit_slot1_order", out_data_o.order, 0);
    tick();

    // fill to full, then drop
    do_reset();
    out_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, 32'h2000 + 32'(i * 8), 32'h2004 + 32'(i * 8));
      tick();
    end
    chk("lit_cnt6_rdy", in_rdy_o, 1);
    set_in(2'b11, 32'h2018, 32'h201c);
    tick();
    chk("lit_full_rdy", in_rdy_o, 0);
    set_in(2'b11, 32'h3000, 32'h3004);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_drop2", drop_cnt_o, DROP_EN ? 2 : 0);
    chk("lit_full_head_order", out_data_o.order, 0);
    out_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("lit_drained", out_valid_o, 0);
    out_rdy_i = 1'b0;
    set_in(2'b01, 32'h4000, 32'h0);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_order_cont", out_data_o.order, 8);
    out_rdy_i = 1'b1;
    tick();

    // full with simultaneous pop and dual push
    do_reset();
    out_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(2'b11, 32'h5000 + 32'(i * 8), 32'h5004 + 32'(i * 8));
      tick();
    end
    chk("lit_full2_rdy", in_rdy_o, 0);
    out_rdy_i = 1'b1;
    set_in(2'b11, 32'h6000, 32'h6004);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_cnt7_rdy", in_rdy_o, 0);
    chk("lit_cnt7_drop", drop_cnt_o, DROP_EN ? 2 : 0);
    chk("lit_cnt7_head", out_data_o.order, 1);
    tick();
    chk("lit_cnt6_rdy_again", in_rdy_o, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("lit_full2_drained", out_valid_o, 0);

    // order counter wrap
    out_rdy_i = 1'b0;
    force dut.order_q = '1;
    m_ord = '1;
    #1;
    release dut.order_q;
    set_in(2'b11, 32'h7000, 32'h7004);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_wrap_ones", out_data_o.order, 64'hFFFF_FFFF_FFFF_FFFF);
    out_rdy_i = 1'b1;
    tick();
    chk("lit_wrap_zero", out_data_o.order, 0);
    chk("lit_wrap_pc", out_data_o.pc, 32'h7004);
    tick();

    // reset mid-operation
    out_rdy_i = 1'b0;
    set_in(2'b11, 32'h8000, 32'h8004); tick();
    set_in(2'b11, 32'h8008, 32'h800c); tick();
    set_in(2'b01, 32'h8010, 32'h0);    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_five_valid", out_valid_o, 1);
    do_reset();
    chk("lit_midrst_valid", out_valid_o, 0);
    chk("lit_midrst_rdy", in_rdy_o, 1);
    set_in(2'b01, 32'h200, 32'h0);
    tick();
    set_in(2'b00, 32'h0, 32'h0);
    chk("lit_midrst_order", out_data_o.order, 0);
    chk("lit_midrst_pc", out_data_o.pc, 32'h200);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      set_in(2'($urandom), $urandom, $urandom);
      out_rdy_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    set_in(2'b00, 32'h0, 32'h0);
    out_rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
